// File: rtl/mux_nto1_rr.sv
// ----------------------------------------------------------------------------
// mux_nto1_rr
//   Registered N:1 channel multiplexer with per-channel valid and a downstream
//   ready handshake. The channel is chosen either by an external select
//   (fixed mode) or by a round-robin arbiter that starts scanning at a
//   rotating pointer. The chosen word is captured into the output register
//   one cycle after the combinational grant.
//
// Ports
//   inClock   in   1             rising-edge clock
//   inReset   in   1             asynchronous reset, active-high
//   inData    in   N_CH*DATA_W   channel i at [i*DATA_W +: DATA_W]
//   inValid   in   N_CH          bit i: channel i presents a word
//   inSel     in   SEL_W         channel select, fixed mode only
//   inMode    in   1             0 = fixed select, 1 = round-robin
//   inReady   in   1             downstream accepts outData this cycle
//   outGrant  out  N_CH          one-hot, combinational: channel consumed now
//   outData   out  DATA_W        registered output word
//   outValid  out  1             outData/outChan hold a valid word
//   outChan   out  SEL_W         channel that supplied outData
// ----------------------------------------------------------------------------
module mux_nto1_rr #(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 4,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     inClock,
    input  logic                     inReset,
    input  logic [N_CH*DATA_W-1:0]   inData,
    input  logic [N_CH-1:0]          inValid,
    input  logic [SEL_W-1:0]         inSel,
    input  logic                     inMode,
    input  logic                     inReady,
    output logic [N_CH-1:0]          outGrant,
    output logic [DATA_W-1:0]        outData,
    output logic                     outValid,
    output logic [SEL_W-1:0]         outChan
);

    // Pointer value following a granted channel, wrapping at N_CH-1 (not at
    // 2**SEL_W, so non-power-of-two channel counts rotate correctly).
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] c);
        logic [SEL_W-1:0] n;
        if (int'(c) >= (N_CH - 1)) begin
            n = {SEL_W{1'b0}};
        end else begin
            n = c + {{(SEL_W-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    logic [SEL_W-1:0]  ptr_r;
    logic              fix_found_s;
    logic              rr_found_s;
    logic [SEL_W-1:0]  rr_chan_s;
    logic              found_s;
    logic [SEL_W-1:0]  chan_s;
    logic              load_s;
    logic [DATA_W-1:0] word_s;

    // Fixed-mode lookup; a select beyond the last channel never matches.
    always_comb begin
        fix_found_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(inSel) == i) begin
                fix_found_s = inValid[i];
            end else begin
                fix_found_s = fix_found_s;
            end
        end
    end

    // Round-robin scan: first pass ptr..N_CH-1, second pass 0..ptr-1.
    always_comb begin
        rr_found_s = 1'b0;
        rr_chan_s  = ptr_r;
        for (int i = 0; i < N_CH; i++) begin
            if (!rr_found_s && (i >= int'(ptr_r)) && inValid[i]) begin
                rr_found_s = 1'b1;
                rr_chan_s  = SEL_W'(i);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!rr_found_s && (i < int'(ptr_r)) && inValid[i]) begin
                rr_found_s = 1'b1;
                rr_chan_s  = SEL_W'(i);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Mode select, load decision and the word of the chosen channel.
    always_comb begin
        if (inMode) begin
            found_s = rr_found_s;
            chan_s  = rr_chan_s;
        end else begin
            found_s = fix_found_s;
            chan_s  = inSel;
        end
        // The output register can take a word when empty or being drained.
        load_s = (!outValid || inReady) && found_s;
        word_s = {DATA_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (int'(chan_s) == i) begin
                word_s = inData[i*DATA_W +: DATA_W];
            end else begin
                word_s = word_s;
            end
        end
    end

    // One-hot grant of the consumed channel, suppressed while in reset.
    always_comb begin
        outGrant = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (load_s && !inReset && (int'(chan_s) == i)) begin
                outGrant[i] = 1'b1;
            end else begin
                outGrant[i] = 1'b0;
            end
        end
    end

    // Output register: load, drain (valid drops, data/chan kept) or stall.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            outData  <= {DATA_W{1'b0}};
            outChan  <= {SEL_W{1'b0}};
            outValid <= 1'b0;
        end else if (load_s) begin
            outData  <= word_s;
            outChan  <= chan_s;
            outValid <= 1'b1;
        end else if (inReady) begin
            outValid <= 1'b0;
        end else begin
            outValid <= outValid;
        end
    end

    // Round-robin pointer advances only on a round-robin load.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            ptr_r <= {SEL_W{1'b0}};
        end else if (load_s && inMode) begin
            ptr_r <= next_ptr(chan_s);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule
